alu_sequencer: RTL and testbench

Fetch/decode/execute controller that steps the shared ALU and register file through a program held in instruction memory.
- Fetches 40-bit instructions and splits them into opcode, mode, register and immediate fields.
- Checks source registers against a write scoreboard, then pulses the ALU and waits a fixed number of execute cycles.
- Stops on end-of-program or on a read of a never-written register.
- Sits between instruction memory and alu_top/register_file and replaces testbench-driven sequencing.

---
 rtl/alu_seq_pkg.sv | 74 +++++++
 rtl/reg_scoreboard.sv | 33 +++
 rtl/alu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and instruction-field layout for the ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StCheck,
    StExec,
    StHalt,
    StError
  } seq_state_e;

  localparam logic [1:0] MODE_RR = 2'b00;
  localparam logic [1:0] MODE_RI = 2'b01;
  localparam logic [1:0] MODE_IR = 2'b10;
  localparam logic [1:0] MODE_II = 2'b11;

  localparam int unsigned OPC_HI     = 39;
  localparam int unsigned OPC_LO     = 34;
  localparam int unsigned MODE_HI    = 33;
  localparam int unsigned MODE_LO    = 32;
  localparam int unsigned REG1_HI    = 31;
  localparam int unsigned REG1_LO    = 24;
  localparam int unsigned REG2_RR_HI = 23;
  localparam int unsigned REG2_RR_LO = 16;
  localparam int unsigned REG2_IR_HI = 15;
  localparam int unsigned REG2_IR_LO = 8;
  localparam int unsigned IMM1_HI    = 31;
  localparam int unsigned IMM1_LO    = 16;
  localparam int unsigned IMM2_RI_HI = 23;
  localparam int unsigned IMM2_RI_LO = 8;
  localparam int unsigned IMM2_II_HI = 15;
  localparam int unsigned IMM2_II_LO = 0;

  localparam logic [5:0] MOV_OPCODE_DEFAULT = 6'h1F;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [1:0]  mode;
    logic [7:0]  op1_addr;
    logic [7:0]  op2_addr;
    logic [15:0] op1_imm;
    logic [15:0] op2_imm;
  } dec_fields_t;

  // Fields not used by the instruction's mode decode to zero.
  function automatic dec_fields_t decode_instr(input logic [39:0] instr);
    dec_fields_t d;
    d        = '0;
    d.opcode = instr[OPC_HI:OPC_LO];
    d.mode   = instr[MODE_HI:MODE_LO];
    case (d.mode)
      MODE_RR: begin
        d.op1_addr = instr[REG1_HI:REG1_LO];
        d.op2_addr = instr[REG2_RR_HI:REG2_RR_LO];
      end
      MODE_RI: begin
        d.op1_addr = instr[REG1_HI:REG1_LO];
        d.op2_imm  = instr[IMM2_RI_HI:IMM2_RI_LO];
      end
      MODE_IR: begin
        d.op1_imm  = instr[IMM1_HI:IMM1_LO];
        d.op2_addr = instr[REG2_IR_HI:REG2_IR_LO];
      end
      default: begin
        d.op1_imm  = instr[IMM1_HI:IMM1_LO];
        d.op2_imm  = instr[IMM2_II_HI:IMM2_II_LO];
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Tracks which of the 256 registers have ever been written; reads see
// same-cycle writes.
module reg_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic       we2,
  input  logic [7:0] waddr2,
  input  logic [7:0] raddr1,
  input  logic [7:0] raddr2,
  output logic       rvalid1,
  output logic       rvalid2
);

  logic [255:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (we)  valid_d[waddr]  = 1'b1;
    if (we2) valid_d[waddr2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Reading the next-state vector gives the write bypass for free.
  assign rvalid1 = valid_d[raddr1];
  assign rvalid2 = valid_d[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/check/execute controller driving the ALU from instruction memory.
// Optional single-step control is enabled by defining SEQ_SINGLE_STEP_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_W     = 40,
  parameter int unsigned EXEC_CYCLES = 2,
  parameter logic [5:0]  MOV_OPCODE  = MOV_OPCODE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_en,
  input  logic              step,
`endif
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic              imem_valid,
  output logic [5:0]        alu_opcode,
  output logic [1:0]        alu_mode,
  output logic [7:0]        op1_addr,
  output logic [7:0]        op2_addr,
  output logic [15:0]       op1_imm,
  output logic [15:0]       op2_imm,
  output logic              alu_go,
  input  logic              rf_we,
  input  logic              rf_we2,
  input  logic [7:0]        rf_waddr,
  input  logic [7:0]        rf_waddr2,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [7:0]        err_reg,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   instr_count
);

  localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  seq_state_e  state_q;
  logic [CntW-1:0] exec_cnt_q;
  dec_fields_t dec;
  logic        src1_ok, src2_ok;
  logic        need1, need2, fail1, fail2;
  logic        exec_last;
  logic        step_ok;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_ok = !step_en || step;
`else
  assign step_ok = 1'b1;
`endif

  assign dec       = decode_instr(imem_data);
  assign exec_last = (exec_cnt_q == CntW'(EXEC_CYCLES - 1));

  reg_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .we2     (rf_we2),
    .waddr2  (rf_waddr2),
    .raddr1  (op1_addr),
    .raddr2  (op2_addr),
    .rvalid1 (src1_ok),
    .rvalid2 (src2_ok)
  );

  always_comb begin
    need1 = 1'b0;
    need2 = 1'b0;
    case (alu_mode)
      MODE_RR: begin
        need1 = 1'b1;
        need2 = 1'b1;
      end
      MODE_RI: need1 = (alu_opcode != MOV_OPCODE);
      MODE_IR: need2 = 1'b1;
      default: ;
    endcase
    fail1 = need1 && !src1_ok;
    fail2 = need2 && !src2_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      exec_cnt_q  <= '0;
      imem_addr   <= '0;
      imem_rd_en  <= 1'b0;
      alu_opcode  <= '0;
      alu_mode    <= '0;
      op1_addr    <= '0;
      op2_addr    <= '0;
      op1_imm     <= '0;
      op2_imm     <= '0;
      alu_go      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      err_reg     <= '0;
      pc          <= '0;
      instr_count <= '0;
    end else begin
      alu_go <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            imem_addr   <= '0;
            imem_rd_en  <= 1'b1;
            busy        <= 1'b1;
            state_q     <= StFetch;
          end
        end
        StFetch: begin
          if (step_ok) begin
            imem_rd_en <= 1'b0;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          if (!imem_valid) begin
            busy    <= 1'b0;
            halted  <= 1'b1;
            state_q <= StHalt;
          end else begin
            alu_opcode <= dec.opcode;
            alu_mode   <= dec.mode;
            op1_addr   <= dec.op1_addr;
            op2_addr   <= dec.op2_addr;
            op1_imm    <= dec.op1_imm;
            op2_imm    <= dec.op2_imm;
            state_q    <= StCheck;
          end
        end
        StCheck: begin
          if (fail1 || fail2) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            err_reg <= fail1 ? op1_addr : op2_addr;
            state_q <= StError;
          end else begin
            alu_go     <= 1'b1;
            exec_cnt_q <= '0;
            state_q    <= StExec;
          end
        end
        StExec: begin
          if (exec_last) begin
            instr_count <= instr_count + 1'b1;
            // Last address ends the program rather than wrapping to 0.
            if (&pc) begin
              busy    <= 1'b0;
              halted  <= 1'b1;
              state_q <= StHalt;
            end else begin
              pc         <= pc + 1'b1;
              imem_addr  <= pc + 1'b1;
              imem_rd_en <= 1'b1;
              state_q    <= StFetch;
            end
          end else begin
            exec_cnt_q <= exec_cnt_q + 1'b1;
          end
        end
        StHalt, StError: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a registered imem and ALU write model.
module tb_alu_sequencer;

  localparam logic [5:0] OP_MOV = 6'h1F;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_OR  = 6'h03;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [39:0] imem_data = '0;
  logic        imem_valid = 1'b0;
  logic [5:0]  alu_opcode;
  logic [1:0]  alu_mode;
  logic [7:0]  op1_addr, op2_addr;
  logic [15:0] op1_imm, op2_imm;
  logic        alu_go;
  logic        rf_we = 1'b0;
  logic        rf_we2;
  logic [7:0]  rf_waddr = '0;
  logic [7:0]  rf_waddr2;
  logic        busy, halted, error;
  logic [7:0]  err_reg;
  logic [7:0]  pc;
  logic [8:0]  instr_count;

  logic [39:0] mem   [256];
  logic        mem_v [256];

  int n_checks = 0;
  int n_fail   = 0;
  int go_q[$];
  int fetch0;

  always #5 clk = ~clk;

  alu_sequencer u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_data   (imem_data),
    .imem_valid  (imem_valid),
    .alu_opcode  (alu_opcode),
    .alu_mode    (alu_mode),
    .op1_addr    (op1_addr),
    .op2_addr    (op2_addr),
    .op1_imm     (op1_imm),
    .op2_imm     (op2_imm),
    .alu_go      (alu_go),
    .rf_we       (rf_we),
    .rf_we2      (rf_we2),
    .rf_waddr    (rf_waddr),
    .rf_waddr2   (rf_waddr2),
    .busy        (busy),
    .halted      (halted),
    .error       (error),
    .err_reg     (err_reg),
    .pc          (pc),
    .instr_count (instr_count)
  );

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (imem_rd_en) begin
      imem_data  <= mem[imem_addr];
      imem_valid <= mem_v[imem_addr];
    end
  end

  // ALU model: one cycle after alu_go, the result is written to op1's register.
  always @(negedge clk) begin
    rf_we    = alu_go;
    rf_waddr = op1_addr;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] ins_rr(input logic [5:0] opc, input logic [7:0] r1,
                                         input logic [7:0] r2);
    return {opc, 2'b00, r1, r2, 16'h0000};
  endfunction

  function automatic logic [39:0] ins_ri(input logic [5:0] opc, input logic [7:0] r1,
                                         input logic [15:0] imm);
    return {opc, 2'b01, r1, imm, 8'h00};
  endfunction

  function automatic logic [39:0] ins_ir(input logic [5:0] opc, input logic [15:0] imm,
                                         input logic [7:0] r2);
    return {opc, 2'b10, imm, r2, 8'h00};
  endfunction

  function automatic logic [39:0] ins_ii(input logic [5:0] opc, input logic [15:0] i1,
                                         input logic [15:0] i2);
    return {opc, 2'b11, i1, i2};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]   = '0;
      mem_v[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    start  = 1'b0;
    rf_we2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"}, 64'({busy, halted, error, alu_go, imem_rd_en}), 64'd0);
    check_eq({tag, "_pc"}, 64'({imem_addr, pc, instr_count}), 64'd0);
    check_eq({tag, "_err_reg"}, 64'(err_reg), 64'd0);
    check_eq({tag, "_fields"}, 64'({alu_opcode, alu_mode, op1_addr, op2_addr}), 64'd0);
    check_eq({tag, "_imms"}, 64'({op1_imm, op2_imm}), 64'd0);
  endtask

  // Pulses start, then steps cycle by cycle (k=3 is the first CHECK cycle)
  // until the sequencer stops or the budget expires.
  task automatic run_prog(input int max_cycles, input bit inj, input logic [7:0] inj_addr);
    int k;
    go_q.delete();
    fetch0 = 0;
    @(negedge clk);
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start     = 1'b0;
      rf_we2    = inj && (k == 3);
      rf_waddr2 = inj_addr;
      if (alu_go) go_q.push_back(k);
      if (imem_rd_en && imem_addr == 8'd0) fetch0++;
    end while (!(halted || error) && k < max_cycles);
    rf_we2 = 1'b0;
    check_eq("run_done", 64'(halted || error), 64'd1);
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[0] = ins_ri(OP_MOV, 8'd1, 16'd5);
    mem[1] = ins_ri(OP_MOV, 8'd2, 16'd3);
    mem[2] = ins_rr(OP_ADD, 8'd1, 8'd2);
    for (int i = 0; i < 3; i++) mem_v[i] = 1'b1;
  endtask

  initial begin
    int n;
    int k;
    rst       = 1'b1;
    start     = 1'b0;
    rf_we2    = 1'b0;
    rf_waddr2 = '0;
    clear_mem();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("init");

    // Start ignored while no reset-free program has begun? No: IDLE holds without start.
    repeat (3) @(negedge clk);
    check_eq("idle_no_start", 64'({busy, imem_rd_en}), 64'd0);

    // 1: MOV R1 #5; MOV R2 #3; ADD R1 R2; end.
    do_reset();
    load_prog1();
    run_prog(200, 1'b0, 8'd0);
    check_eq("t1_go_count", 64'(go_q.size()), 64'd3);
    if (go_q.size() == 3) begin
      check_eq("t1_first_go_cycle", 64'(go_q[0]), 64'd4);
      check_eq("t1_period_a", 64'(go_q[1] - go_q[0]), 64'd5);
      check_eq("t1_period_b", 64'(go_q[2] - go_q[1]), 64'd5);
    end
    check_eq("t1_status", 64'({busy, halted, error}), 64'b010);
    check_eq("t1_instr_count", 64'(instr_count), 64'd3);
    check_eq("t1_pc", 64'(pc), 64'd3);
    check_eq("t1_fields", 64'({alu_opcode, alu_mode, op1_addr, op2_addr}),
             64'({OP_ADD, 2'b00, 8'd1, 8'd2}));

    // 2: ADD R4 R7 with an empty scoreboard; op1 wins priority.
    do_reset();
    clear_mem();
    mem[0] = ins_rr(OP_ADD, 8'd4, 8'd7);
    mem_v[0] = 1'b1;
    run_prog(100, 1'b0, 8'd0);
    check_eq("t2_status", 64'({busy, halted, error}), 64'b001);
    check_eq("t2_err_reg", 64'(err_reg), 64'd4);
    check_eq("t2_go_count", 64'(go_q.size()), 64'd0);
    check_eq("t2_instr_count", 64'(instr_count), 64'd0);

    // 3: MOV R9 #1; OR #2 R10 -> R10 never written.
    do_reset();
    clear_mem();
    mem[0] = ins_ri(OP_MOV, 8'd9, 16'd1);
    mem[1] = ins_ir(OP_OR, 16'd2, 8'd10);
    mem_v[0] = 1'b1;
    mem_v[1] = 1'b1;
    run_prog(100, 1'b0, 8'd0);
    check_eq("t3_error", 64'(error), 64'd1);
    check_eq("t3_err_reg", 64'(err_reg), 64'd10);
    check_eq("t3_instr_count", 64'(instr_count), 64'd1);
    check_eq("t3_pc", 64'(pc), 64'd1);
    check_eq("t3_fields", 64'({alu_opcode, alu_mode, op1_addr, op2_addr}),
             64'({OP_OR, 2'b10, 8'd0, 8'd10}));
    check_eq("t3_imms", 64'({op1_imm, op2_imm}), 64'({16'd2, 16'd0}));

    // 3b: MOV R5 #7; ADD R5 R6 -> op1 present, op2 reported.
    do_reset();
    clear_mem();
    mem[0] = ins_ri(OP_MOV, 8'd5, 16'd7);
    mem[1] = ins_rr(OP_ADD, 8'd5, 8'd6);
    mem_v[0] = 1'b1;
    mem_v[1] = 1'b1;
    run_prog(100, 1'b0, 8'd0);
    check_eq("t3b_err_reg", 64'(err_reg), 64'd6);
    check_eq("t3b_go_count", 64'(go_q.size()), 64'd1);

    // 4: SUB R3 #1 with R3 written during the CHECK cycle.
    do_reset();
    clear_mem();
    mem[0] = ins_ri(OP_SUB, 8'd3, 16'd1);
    mem_v[0] = 1'b1;
    run_prog(100, 1'b1, 8'd3);
    check_eq("t4_status", 64'({halted, error}), 64'b10);
    check_eq("t4_go_count", 64'(go_q.size()), 64'd1);
    check_eq("t4_fields", 64'({alu_opcode, alu_mode, op1_addr, op2_imm}),
             64'({OP_SUB, 2'b01, 8'd3, 16'd1}));
    check_eq("t4_instr_count", 64'(instr_count), 64'd1);

    // 5: 256 immediate-only instructions, no wrap past pc 255.
    do_reset();
    clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]   = ins_ii(OP_ADD, 16'(i), 16'hBEEF);
      mem_v[i] = 1'b1;
    end
    run_prog(2000, 1'b0, 8'd0);
    check_eq("t5_status", 64'({busy, halted, error}), 64'b010);
    check_eq("t5_instr_count", 64'(instr_count), 64'd256);
    check_eq("t5_pc", 64'(pc), 64'd255);
    check_eq("t5_go_count", 64'(go_q.size()), 64'd256);
    check_eq("t5_fetch0_count", 64'(fetch0), 64'd1);
    check_eq("t5_imms", 64'({op1_imm, op2_imm}), 64'({16'd255, 16'hBEEF}));

    // 6: reset during EXEC of the second instruction, then rerun from pc 0.
    do_reset();
    load_prog1();
    @(negedge clk);
    start = 1'b1;
    n = 0;
    k = 0;
    while (n < 2 && k < 100) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (alu_go) n++;
    end
    check_eq("t6_second_go_seen", 64'(n), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t6_rst");
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (alu_go) n++;
    end
    check_eq("t6_no_go_after_rst", 64'(n), 64'd0);
    check_eq("t6_idle_busy", 64'(busy), 64'd0);
    // R1 was written before the reset; a cleared scoreboard must flag R1 first.
    clear_mem();
    mem[0] = ins_rr(OP_ADD, 8'd1, 8'd2);
    mem_v[0] = 1'b1;
    run_prog(100, 1'b0, 8'd0);
    check_eq("t6_rerun_error", 64'(error), 64'd1);
    check_eq("t6_rerun_err_reg", 64'(err_reg), 64'd1);
    check_eq("t6_rerun_pc", 64'(pc), 64'd0);
    check_eq("t6_rerun_fetch0", 64'(fetch0), 64'd1);

    // Start is ignored once in ERROR.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("error_sticky", 64'({busy, error, imem_rd_en}), 64'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
